// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
//
// Reset/lock sequencer for the system PLL. Runs on the free-running reference
// clock so it keeps working while the PLL output is absent. Holds the PLL in
// reset after power-up, waits for lock, requires lock to stay up for a
// qualification window, then releases the downstream reset. A lock loss while
// running restarts the sequence and is counted; a lock that never arrives is
// retried a bounded number of times before a sticky failure is flagged.
//
// Ports
//   refclk     in   1  reference clock, all logic on rising edge
//   reset      in   1  synchronous active-high reset
//   extlock    in   1  PLL lock indicator, asynchronous to refclk
//   pll_reset  out  1  PLL reset request (high = PLL held in reset)
//   sys_rst    out  1  downstream reset, high until lock is qualified
//   pll_ok     out  1  high only while running with a qualified lock
//   lock_fail  out  1  sticky failure flag, cleared only by reset
//   relock_cnt out  8  saturating count of lock losses seen while running
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pll_reset_seq #(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned PLL_RST_CYCLES      = 24,
    parameter int unsigned LOCK_STABLE_CYCLES  = 24000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 240000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       pll_ok,
    output logic       lock_fail,
    output logic [7:0] relock_cnt
);

    // Each counter only has to hold 0..N-1; a 1-bit floor keeps N=1 legal.
    localparam int unsigned RST_W   = (PLL_RST_CYCLES      > 1) ? $clog2(PLL_RST_CYCLES)      : 1;
    localparam int unsigned STAB_W  = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int unsigned TO_W    = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [RST_W-1:0]       r_rst_cnt;
    logic [STAB_W-1:0]      r_stab_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic [RETRY_W-1:0]     r_retry;
    logic                   r_pll_reset;
    logic                   r_sys_rst;
    logic                   r_pll_ok;
    logic                   r_lock_fail;
    logic [7:0]             r_relock_cnt;

    logic                   w_lock_s;

    assign w_lock_s   = r_sync[SYNC_STAGES-1];

    assign pll_reset  = r_pll_reset;
    assign sys_rst    = r_sys_rst;
    assign pll_ok     = r_pll_ok;
    assign lock_fail  = r_lock_fail;
    assign relock_cnt = r_relock_cnt;

    always_ff @(posedge refclk) begin
        if (reset) begin
            r_state      <= ST_PLL_RST;
            r_sync       <= '0;
            r_rst_cnt    <= '0;
            r_stab_cnt   <= '0;
            r_to_cnt     <= '0;
            r_retry      <= '0;
            r_pll_reset  <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_pll_ok     <= 1'b0;
            r_lock_fail  <= 1'b0;
            r_relock_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], extlock};

            // Outputs are set on the transition edge so they change together
            // with the state register.
            case (r_state)
                ST_PLL_RST: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_pll_reset <= 1'b0;
                        r_rst_cnt   <= '0;
                        r_to_cnt    <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock is tested before the timeout so a lock arriving on
                    // the timeout cycle does not burn a retry.
                    if (w_lock_s) begin
                        r_state    <= ST_STABLE;
                        r_stab_cnt <= '0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_to_cnt    <= '0;
                        r_retry     <= r_retry + 1'b1;
                        r_pll_reset <= 1'b1;
                        if (r_retry == RETRY_LAST) begin
                            r_state     <= ST_FAIL;
                            r_lock_fail <= 1'b1;
                        end else begin
                            r_state   <= ST_PLL_RST;
                            r_rst_cnt <= '0;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                ST_STABLE: begin
                    // Timeout count is deliberately kept across a glitch so a
                    // chattering lock still times out.
                    if (!w_lock_s) begin
                        r_state    <= ST_WAIT_LOCK;
                        r_stab_cnt <= '0;
                    end else if (r_stab_cnt == STAB_LAST) begin
                        r_state    <= ST_RUN;
                        r_stab_cnt <= '0;
                        r_retry    <= '0;
                        r_sys_rst  <= 1'b0;
                        r_pll_ok   <= 1'b1;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    r_retry <= '0;
                    if (!w_lock_s) begin
                        r_state     <= ST_PLL_RST;
                        r_rst_cnt   <= '0;
                        r_pll_reset <= 1'b1;
                        r_sys_rst   <= 1'b1;
                        r_pll_ok    <= 1'b0;
                        if (r_relock_cnt != 8'hFF) begin
                            r_relock_cnt <= r_relock_cnt + 8'd1;
                        end
                    end
                end

                ST_FAIL: begin
                    r_pll_reset <= 1'b1;
                    r_sys_rst   <= 1'b1;
                    r_pll_ok    <= 1'b0;
                    r_lock_fail <= 1'b1;
                end

                default: begin
                    r_state     <= ST_PLL_RST;
                    r_rst_cnt   <= '0;
                    r_pll_reset <= 1'b1;
                    r_sys_rst   <= 1'b1;
                    r_pll_ok    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Self-checking bench for pll_reset_seq with short parameters. A table of
// {reset, extlock, cycles, expected outputs} rows covers power-up and a single
// lock loss cycle by cycle; hand-written sequences cover the glitch in the
// qualification window, the timeout/retry/fail path, relock saturation and
// reset taken from the middle of a sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pll_reset_seq;

    localparam int unsigned SYNC = 2;
    localparam int unsigned RSTC = 4;
    localparam int unsigned STAB = 16;
    localparam int unsigned TOUT = 64;
    localparam int unsigned RETR = 2;

    logic       refclk = 1'b0;
    logic       reset  = 1'b1;
    logic       extlock = 1'b0;
    logic       pll_reset;
    logic       sys_rst;
    logic       pll_ok;
    logic       lock_fail;
    logic [7:0] relock_cnt;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    pll_reset_seq #(
        .SYNC_STAGES        (SYNC),
        .PLL_RST_CYCLES     (RSTC),
        .LOCK_STABLE_CYCLES (STAB),
        .LOCK_TIMEOUT_CYCLES(TOUT),
        .MAX_RETRIES        (RETR)
    ) dut (
        .refclk    (refclk),
        .reset     (reset),
        .extlock   (extlock),
        .pll_reset (pll_reset),
        .sys_rst   (sys_rst),
        .pll_ok    (pll_ok),
        .lock_fail (lock_fail),
        .relock_cnt(relock_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string       name;
        logic        rst;
        logic        ext;
        int unsigned ncyc;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[11];

    // Output bundle: {pll_reset, sys_rst, pll_ok, lock_fail, relock_cnt}
    function automatic logic [11:0] obs();
        return {pll_reset, sys_rst, pll_ok, lock_fail, relock_cnt};
    endfunction

    function automatic logic [11:0] ex(input logic pr, input logic sr, input logic ok,
                                       input logic lf, input logic [7:0] cnt);
        return {pr, sr, ok, lf, cnt};
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    // Ticks until sys_rst is low, bounded; returns the number of ticks taken.
    task automatic wait_sys_low(input int unsigned limit, output int unsigned n);
        n = 0;
        while (sys_rst !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ok(input logic val, input int unsigned limit, input string name);
        int unsigned n;
        n = 0;
        while (pll_ok !== val && n < limit) begin
            tick();
            n++;
        end
        chk(name, {31'd0, pll_ok}, {31'd0, val});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic        epr, elf;

        // Power-up (extlock first sampled on edge 10 after release) and a
        // one-cycle lock drop in RUN.
        vecs[0]  = '{"t1_reset",     1'b1, 1'b0, 3,  ex(1, 1, 0, 0, 0)};
        vecs[1]  = '{"t1_pllrst",    1'b0, 1'b0, 3,  ex(1, 1, 0, 0, 0)};
        vecs[2]  = '{"t1_wait",      1'b0, 1'b0, 6,  ex(0, 1, 0, 0, 0)};
        vecs[3]  = '{"t1_qualify",   1'b0, 1'b1, 18, ex(0, 1, 0, 0, 0)};
        vecs[4]  = '{"t1_run",       1'b0, 1'b1, 4,  ex(0, 0, 1, 0, 0)};
        vecs[5]  = '{"t2_drop",      1'b0, 1'b0, 1,  ex(0, 0, 1, 0, 0)};
        vecs[6]  = '{"t2_synclag",   1'b0, 1'b1, 1,  ex(0, 0, 1, 0, 0)};
        vecs[7]  = '{"t2_pllrst",    1'b0, 1'b1, 4,  ex(1, 1, 0, 0, 1)};
        vecs[8]  = '{"t2_wait",      1'b0, 1'b1, 1,  ex(0, 1, 0, 0, 1)};
        vecs[9]  = '{"t2_stable",    1'b0, 1'b1, 16, ex(0, 1, 0, 0, 1)};
        vecs[10] = '{"t2_rerun",     1'b0, 1'b1, 3,  ex(0, 0, 1, 0, 1)};

        for (int unsigned i = 0; i < 11; i++) begin
            reset   = vecs[i].rst;
            extlock = vecs[i].ext;
            for (int unsigned c = 0; c < vecs[i].ncyc; c++) begin
                tick();
                chk(vecs[i].name, {20'd0, obs()}, {20'd0, vecs[i].exp});
            end
        end

        // Glitch at stable count 10: lock returns on edge 17 and RUN must come
        // 18 edges after that, i.e. on the 19th tick counted from edge 17.
        reset = 1'b1; extlock = 1'b1;
        tick();
        reset = 1'b0;
        repeat (15) tick();
        extlock = 1'b0;
        tick();
        chk("t3_glitch_hold", {20'd0, obs()}, {20'd0, ex(0, 1, 0, 0, 0)});
        extlock = 1'b1;
        wait_sys_low(200, n);
        chk("t3_requalify_latency", n, 1 + SYNC + STAB);
        chk("t3_run", {20'd0, obs()}, {20'd0, ex(0, 0, 1, 0, 0)});

        // Reset taken mid-STABLE, then a clean restart.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("t6_pre_stable", {20'd0, obs()}, {20'd0, ex(0, 1, 0, 0, 0)});
        reset = 1'b1;
        tick();
        chk("t6_reset_stable", {20'd0, obs()}, {20'd0, ex(1, 1, 0, 0, 0)});
        reset = 1'b0;
        wait_sys_low(200, n);
        chk("t6_restart_latency", n, RSTC + 1 + STAB);

        // Lock never arrives: two PLL reset pulses, two timeouts, then FAIL.
        reset = 1'b1; extlock = 1'b0;
        tick();
        reset = 1'b0;
        for (int unsigned k = 1; k <= 140; k++) begin
            tick();
            epr = (k < RSTC) || (k >= RSTC + TOUT && k < 2 * RSTC + TOUT) ||
                  (k >= 2 * (RSTC + TOUT));
            elf = (k >= 2 * (RSTC + TOUT));
            chk("t4_timeline", {20'd0, obs()}, {20'd0, ex(epr, 1, 0, elf, 0)});
        end
        extlock = 1'b1;
        for (int unsigned k = 0; k < 40; k++) begin
            tick();
            chk("t4_fail_sticky", {20'd0, obs()}, {20'd0, ex(1, 1, 0, 1, 0)});
        end
        reset = 1'b1;
        tick();
        chk("t4_fail_reset", {20'd0, obs()}, {20'd0, ex(1, 1, 0, 0, 0)});
        reset = 1'b0;
        wait_sys_low(200, n);
        chk("t4_restart_latency", n, RSTC + 1 + STAB);

        // 300 lock losses; relock_cnt must stop at 255.
        for (int unsigned i = 0; i < 300; i++) begin
            extlock = 1'b0;
            tick();
            extlock = 1'b1;
            wait_ok(1'b0, 8, "t5_drop_seen");
            wait_ok(1'b1, 64, "t5_relocked");
            chk("t5_relock_cnt", {24'd0, relock_cnt}, (i + 1 > 255) ? 255 : i + 1);
        end

        // Reset taken mid-RUN with a saturated counter.
        reset = 1'b1;
        tick();
        chk("t6_reset_run", {20'd0, obs()}, {20'd0, ex(1, 1, 0, 0, 0)});
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
